// File: rtl/ofdm_pkg.sv
// Shared OFDM receive definitions: FFT/CP geometry as functions of NFFT,
// frame-timing limits, stream metadata field widths and the CP remover state type.
package ofdm_pkg;

    localparam int SFN_MAX             = 1023;
    localparam int SUBFRAMES_PER_FRAME = 10;
    localparam int SYM_PER_SF          = 14;

    localparam int SFN_W      = $clog2(SFN_MAX + 1);
    localparam int SF_W       = $clog2(SUBFRAMES_PER_FRAME);
    localparam int SYM_W      = $clog2(SYM_PER_SF);
    // wide enough for MAX_CP_LEN up to NFFT=12
    localparam int CP_W       = 9;
    localparam int META_W     = SFN_W + SF_W + SYM_W;
    localparam int USER_WIDTH = META_W + CP_W;

    function automatic int fft_len(input int nfft);
        return 1 << nfft;
    endfunction

    function automatic int cp1_len(input int nfft);
        return 20 * fft_len(nfft) / 256;
    endfunction

    function automatic int cp2_len(input int nfft);
        return 18 * fft_len(nfft) / 256;
    endfunction

    function automatic int max_cp_len(input int nfft);
        return cp1_len(nfft);
    endfunction

    typedef enum logic [1:0] {
        ST_ALIGN,
        ST_SKIP,
        ST_PASS,
        ST_TAIL
    } cp_rm_state_t;

endpackage

// File: rtl/cp_remover_if.sv
// Sample stream in from frame_sync, FFT stream out plus symbol/error pulses.
// slave = CP remover side, master = producer/consumer side.
interface cp_remover_if #(
    parameter int IN_DW = 32
);
    import ofdm_pkg::*;

    logic [IN_DW-1:0]      s_axis_in_tdata;
    logic [USER_WIDTH-1:0] s_axis_in_tuser;
    logic                  s_axis_in_tlast;
    logic                  s_axis_in_tvalid;

    logic [IN_DW-1:0]      m_axis_out_tdata;
    logic [META_W-1:0]     m_axis_out_tuser;
    logic                  m_axis_out_tlast;
    logic                  m_axis_out_tvalid;

    logic                  sym_start_o;
    logic                  err_short_o;
    logic                  err_long_o;

    modport slave (
        input  s_axis_in_tdata, s_axis_in_tuser, s_axis_in_tlast, s_axis_in_tvalid,
        output m_axis_out_tdata, m_axis_out_tuser, m_axis_out_tlast, m_axis_out_tvalid,
        output sym_start_o, err_short_o, err_long_o
    );

    modport master (
        output s_axis_in_tdata, s_axis_in_tuser, s_axis_in_tlast, s_axis_in_tvalid,
        input  m_axis_out_tdata, m_axis_out_tuser, m_axis_out_tlast, m_axis_out_tvalid,
        input  sym_start_o, err_short_o, err_long_o
    );

endinterface

// File: rtl/cp_remover.sv
// Strips the cyclic prefix from each symbol and forwards FFT_LEN samples, 1-cycle latency.
// Define CP_ADVANCE_EN to keep CP_ADVANCE prefix samples and drop the same number at symbol end.
module cp_remover
    import ofdm_pkg::*;
#(
    parameter int IN_DW      = 32,
    parameter int NFFT       = 8,
    parameter int CP_ADVANCE = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    cp_remover_if.slave  bus
);

    localparam int FFT_LEN = fft_len(NFFT);
    localparam int MAX_CP  = max_cp_len(NFFT);
    localparam int CNT_W   = $clog2(FFT_LEN + MAX_CP);

`ifdef CP_ADVANCE_EN
    localparam bit ADV_EN = 1'b1;
`else
    localparam bit ADV_EN = 1'b0;
`endif
    localparam bit ADV_TAIL = ADV_EN && (CP_ADVANCE > 0);

    typedef logic [CNT_W-1:0] cnt_t;

    cp_rm_state_t      state_q, state_d;
    cnt_t              cnt_q, cnt_d;
    cnt_t              skip_q, skip_d;
    logic [META_W-1:0] meta_q, meta_d;

    logic              vld, tlast;
    logic [CP_W-1:0]   in_cp, cp_clamp;
    logic [META_W-1:0] in_meta;
    cnt_t              skip_new, skip_eff;
    logic              direct, skip_done, last_pass, tail_end;

    assign vld     = bus.s_axis_in_tvalid;
    assign tlast   = bus.s_axis_in_tlast;
    assign in_cp   = bus.s_axis_in_tuser[CP_W-1:0];
    assign in_meta = bus.s_axis_in_tuser[USER_WIDTH-1:CP_W];

    assign cp_clamp = (in_cp > CP_W'(MAX_CP)) ? CP_W'(MAX_CP) : in_cp;
    assign skip_new = !ADV_EN                         ? cnt_t'(cp_clamp) :
                      (cp_clamp > CP_W'(CP_ADVANCE))  ? cnt_t'(cp_clamp - CP_W'(CP_ADVANCE)) :
                                                        '0;
    // skip length is only known from the symbol's first sample (cnt_q == 0)
    assign skip_eff  = (cnt_q == '0) ? skip_new : skip_q;
    assign direct    = (cnt_q == '0) && (skip_new == '0);
    assign skip_done = (cnt_q == skip_eff - 1'b1);
    assign last_pass = (cnt_q == cnt_t'(FFT_LEN - 1));
    assign tail_end  = (cnt_q == cnt_t'(CP_ADVANCE - 1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_ALIGN;
            cnt_q   <= '0;
            skip_q  <= '0;
            meta_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            skip_q  <= skip_d;
            meta_q  <= meta_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        skip_d  = skip_q;
        meta_d  = meta_q;
        if (vld) begin
            case (state_q)
                ST_ALIGN: begin
                    if (tlast) begin
                        state_d = ST_SKIP;
                        cnt_d   = '0;
                    end
                end
                ST_SKIP: begin
                    if (cnt_q == '0) begin
                        meta_d = in_meta;
                        skip_d = skip_new;
                    end
                    if (tlast) begin
                        state_d = ST_SKIP;
                        cnt_d   = '0;
                    end else if (direct) begin
                        state_d = ST_PASS;
                        cnt_d   = cnt_t'(1);
                    end else if (skip_done) begin
                        state_d = ST_PASS;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_PASS: begin
                    if (last_pass) begin
                        cnt_d = '0;
                        if (tlast)         state_d = ST_SKIP;
                        else if (ADV_TAIL) state_d = ST_TAIL;
                        else               state_d = ST_ALIGN;
                    end else if (tlast) begin
                        state_d = ST_SKIP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (tlast) begin
                        state_d = ST_SKIP;
                        cnt_d   = '0;
                    end else if (tail_end) begin
                        state_d = ST_ALIGN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    logic fwd, first, out_last, short_err, long_err;

    always_comb begin
        fwd       = 1'b0;
        first     = 1'b0;
        out_last  = 1'b0;
        short_err = 1'b0;
        long_err  = 1'b0;
        if (vld) begin
            case (state_q)
                ST_SKIP: begin
                    fwd       = direct;
                    first     = direct;
                    short_err = tlast;
                end
                ST_PASS: begin
                    fwd       = 1'b1;
                    first     = (cnt_q == '0);
                    out_last  = last_pass;
                    short_err = tlast && !last_pass;
                    long_err  = !tlast && last_pass && !ADV_TAIL;
                end
                ST_TAIL: begin
                    short_err = tlast && !tail_end;
                    long_err  = !tlast && tail_end;
                end
                default: ;
            endcase
        end
    end

    logic [IN_DW-1:0]  tdata_q;
    logic [META_W-1:0] tuser_q;
    logic              tvalid_q, tlast_q, start_q, short_q, long_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tdata_q  <= '0;
            tuser_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            start_q  <= 1'b0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
        end else begin
            tvalid_q <= fwd;
            tlast_q  <= out_last;
            start_q  <= first;
            short_q  <= short_err;
            long_q   <= long_err;
            if (fwd) begin
                tdata_q <= bus.s_axis_in_tdata;
                // a direct (zero-skip) first sample has not reached meta_q yet
                tuser_q <= (state_q == ST_SKIP) ? in_meta : meta_q;
            end
        end
    end

    assign bus.m_axis_out_tdata  = tdata_q;
    assign bus.m_axis_out_tuser  = tuser_q;
    assign bus.m_axis_out_tvalid = tvalid_q;
    assign bus.m_axis_out_tlast  = tlast_q;
    assign bus.sym_start_o       = start_q;
    assign bus.err_short_o       = short_q;
    assign bus.err_long_o        = long_q;

endmodule

// File: tb/tb_cp_remover.sv
// Directed bench for cp_remover (NFFT=8); expectations follow CP_ADVANCE_EN when defined.
module tb_cp_remover;
    import ofdm_pkg::*;

    localparam int NFFT = 8;
    localparam int FFT  = 256;
    localparam int CPA  = 4;
`ifdef CP_ADVANCE_EN
    localparam int A = CPA;
`else
    localparam int A = 0;
`endif

    typedef struct packed {
        logic [31:0]       d;
        logic [META_W-1:0] u;
        logic              l;
        logic              s;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cp_remover_if #(.IN_DW(32)) bus ();

    cp_remover #(.IN_DW(32), .NFFT(NFFT), .CP_ADVANCE(CPA)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    rec_t out_q[$];
    rec_t exp_q[$];
    int   checks = 0, errors = 0;
    int   n_short, n_long, lat_bad;
    logic        cap_v;
    logic [31:0] cap_d;

    always @(posedge clk) begin
        cap_v <= bus.s_axis_in_tvalid;
        cap_d <= bus.s_axis_in_tdata;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.m_axis_out_tvalid) begin
                out_q.push_back('{bus.m_axis_out_tdata, bus.m_axis_out_tuser,
                                  bus.m_axis_out_tlast, bus.sym_start_o});
                if (!(cap_v === 1'b1 && cap_d === bus.m_axis_out_tdata)) lat_bad++;
            end
            if (bus.err_short_o) n_short++;
            if (bus.err_long_o)  n_long++;
        end
    end

    function automatic logic [META_W-1:0] mk(input int sfn, input int sf, input int sym);
        return {SFN_W'(sfn), SF_W'(sf), SYM_W'(sym)};
    endfunction

    task automatic clear();
        out_q.delete();
        exp_q.delete();
        n_short = 0;
        n_long  = 0;
        lat_bad = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.s_axis_in_tvalid = 1'b0;
        bus.s_axis_in_tlast  = 1'b0;
        bus.s_axis_in_tdata  = '0;
        bus.s_axis_in_tuser  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 bus.s_axis_in_tvalid = 1'b0;
            bus.s_axis_in_tlast = 1'b0;
        end
    endtask

    // tuser is scrambled after sample 0 so any late re-latching shows up
    task automatic send(input int tag, input int cp, input int n, input int tl,
                        input logic [META_W-1:0] meta, input int gap);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap) idle(1);
            @(posedge clk);
            #1;
            bus.s_axis_in_tvalid = 1'b1;
            bus.s_axis_in_tdata  = {8'(tag), 8'h00, 16'(i)};
            bus.s_axis_in_tuser  = (i == 0) ? {meta, CP_W'(cp)} : {~meta, CP_W'(i)};
            bus.s_axis_in_tlast  = (i == tl);
        end
    endtask

    task automatic expect_sym(input int tag, input int cp, input int nout, input bit full,
                              input logic [META_W-1:0] meta);
        int cpc, first;
        cpc   = (cp > 20) ? 20 : cp;
        first = (cpc > A) ? cpc - A : 0;
        for (int k = 0; k < nout; k++)
            exp_q.push_back('{{8'(tag), 8'h00, 16'(first + k)}, meta, full && (k == FFT - 1), k == 0});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.s_axis_in_tvalid = 1'b1;
        bus.s_axis_in_tlast  = 1'b1;
        bus.s_axis_in_tdata  = 32'hdead_beef;
        bus.s_axis_in_tuser  = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.m_axis_out_tvalid, bus.m_axis_out_tdata, bus.m_axis_out_tuser, bus.m_axis_out_tlast,
             bus.sym_start_o, bus.err_short_o, bus.err_long_o} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got valid=%b data=%h user=%h last=%b start=%b es=%b el=%b, all 0 required",
                     bus.m_axis_out_tvalid, bus.m_axis_out_tdata, bus.m_axis_out_tuser,
                     bus.m_axis_out_tlast, bus.sym_start_o, bus.err_short_o, bus.err_long_o);
        end
        #1 rst = 1'b0;
        bus.s_axis_in_tvalid = 1'b0;
        bus.s_axis_in_tlast  = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.m_axis_out_tvalid, bus.sym_start_o, bus.err_short_o, bus.err_long_o} !== 4'b0) begin
            errors++;
            $display("FAIL reset idle: got valid=%b start=%b es=%b el=%b, all 0 required",
                     bus.m_axis_out_tvalid, bus.sym_start_o, bus.err_short_o, bus.err_long_o);
        end
    endtask

    task automatic test_symbols(input int gap);
        int bad;
        do_reset();
        clear();
        send(1, 20, 276, 275, mk(5, 1, 0), gap);
        send(2, 18, 274, 273, mk(5, 1, 1), gap);
        send(3, 18, 274, 273, mk(5, 1, 2), gap);
        idle(4);
        expect_sym(2, 18, FFT, 1'b1, mk(5, 1, 1));
        expect_sym(3, 18, FFT, 1'b1, mk(5, 1, 2));
        checks++;
        if (out_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL symbols(gap=%0d) count: got %0d required %0d", gap, out_q.size(), exp_q.size());
        end
        checks++;
        bad = 0;
        for (int k = 0; k < exp_q.size() && k < out_q.size(); k++)
            if (out_q[k] !== exp_q[k]) begin
                if (bad == 0) $display("FAIL symbols(gap=%0d) sample %0d: got %h required %h", gap, k, out_q[k], exp_q[k]);
                bad++;
            end
        if (bad != 0) errors++;
        checks++;
        if ({n_short, n_long} !== {32'd0, 32'd0}) begin
            errors++;
            $display("FAIL symbols(gap=%0d) errors: got short=%0d long=%0d required 0/0", gap, n_short, n_long);
        end
        checks++;
        if (lat_bad !== 0) begin
            errors++;
            $display("FAIL symbols(gap=%0d) latency: got %0d late/spurious outputs required 0", gap, lat_bad);
        end
    endtask

    task automatic test_gaps();
        test_symbols(50);
    endtask

    task automatic test_short();
        int bad;
        do_reset();
        send(1, 20, 276, 275, mk(7, 2, 0), 0);
        idle(2);
        clear();
        send(4, 20, 200, 199, mk(7, 2, 1), 0);
        send(5, 18, 274, 273, mk(7, 2, 2), 0);
        idle(4);
        expect_sym(4, 20, 200 - (20 - A), 1'b0, mk(7, 2, 1));
        expect_sym(5, 18, FFT, 1'b1, mk(7, 2, 2));
        checks++;
        bad = (out_q.size() != exp_q.size()) ? 1 : 0;
        for (int k = 0; k < exp_q.size() && k < out_q.size(); k++)
            if (out_q[k] !== exp_q[k]) begin
                if (bad == 0) $display("FAIL short sample %0d: got %h required %h", k, out_q[k], exp_q[k]);
                bad++;
            end
        if (bad != 0) begin
            errors++;
            $display("FAIL short sequence: got %0d samples/%0d bad, required %0d samples", out_q.size(), bad, exp_q.size());
        end
        checks++;
        if (n_short !== 1) begin
            errors++;
            $display("FAIL short err_short: got %0d cycles required 1", n_short);
        end
        checks++;
        if (n_long !== 0) begin
            errors++;
            $display("FAIL short err_long: got %0d cycles required 0", n_long);
        end
    endtask

    task automatic test_long();
        int bad;
        do_reset();
        send(1, 20, 276, 275, mk(9, 3, 0), 0);
        idle(2);
        clear();
        send(6, 18, 280, 279, mk(9, 3, 1), 0);
        send(7, 18, 274, 273, mk(9, 3, 2), 0);
        idle(4);
        expect_sym(6, 18, FFT, 1'b1, mk(9, 3, 1));
        expect_sym(7, 18, FFT, 1'b1, mk(9, 3, 2));
        checks++;
        bad = (out_q.size() != exp_q.size()) ? 1 : 0;
        for (int k = 0; k < exp_q.size() && k < out_q.size(); k++)
            if (out_q[k] !== exp_q[k]) begin
                if (bad == 0) $display("FAIL long sample %0d: got %h required %h", k, out_q[k], exp_q[k]);
                bad++;
            end
        if (bad != 0) begin
            errors++;
            $display("FAIL long sequence: got %0d samples/%0d bad, required %0d samples", out_q.size(), bad, exp_q.size());
        end
        checks++;
        if (n_long !== 1) begin
            errors++;
            $display("FAIL long err_long: got %0d cycles required 1", n_long);
        end
        checks++;
        if (n_short !== 0) begin
            errors++;
            $display("FAIL long err_short: got %0d cycles required 0", n_short);
        end
    endtask

    task automatic test_cp_edges();
        int bad;
        do_reset();
        send(1, 20, 276, 275, mk(11, 4, 0), 0);
        idle(2);
        clear();
        send(11, 0, 256, 255, mk(11, 4, 1), 0);
        send(12, 25, 276, 275, mk(11, 4, 2), 0);
        send(13, 1, 257, 256, mk(11, 4, 3), 30);
        idle(4);
        expect_sym(11, 0, FFT, 1'b1, mk(11, 4, 1));
        expect_sym(12, 25, FFT, 1'b1, mk(11, 4, 2));
        expect_sym(13, 1, FFT, 1'b1, mk(11, 4, 3));
        checks++;
        bad = (out_q.size() != exp_q.size()) ? 1 : 0;
        for (int k = 0; k < exp_q.size() && k < out_q.size(); k++)
            if (out_q[k] !== exp_q[k]) begin
                if (bad == 0) $display("FAIL cp_edges sample %0d: got %h required %h", k, out_q[k], exp_q[k]);
                bad++;
            end
        if (bad != 0) begin
            errors++;
            $display("FAIL cp_edges sequence: got %0d samples/%0d bad, required %0d samples", out_q.size(), bad, exp_q.size());
        end
        checks++;
        if ({n_short, n_long} !== {32'd0, 32'd0}) begin
            errors++;
            $display("FAIL cp_edges errors: got short=%0d long=%0d required 0/0", n_short, n_long);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        do_reset();
        send(1, 20, 276, 275, mk(13, 5, 0), 0);
        idle(2);
        clear();
        send(8, 18, 118, -1, mk(13, 5, 1), 0);
        idle(1);
        @(posedge clk);
        #1 rst = 1'b1;
        bus.s_axis_in_tvalid = 1'b1;
        bus.s_axis_in_tlast  = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.m_axis_out_tvalid, bus.m_axis_out_tdata, bus.m_axis_out_tuser, bus.m_axis_out_tlast,
             bus.sym_start_o, bus.err_short_o, bus.err_long_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs: got valid=%b data=%h user=%h, all 0 required",
                     bus.m_axis_out_tvalid, bus.m_axis_out_tdata, bus.m_axis_out_tuser);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        bus.s_axis_in_tvalid = 1'b0;
        bus.s_axis_in_tlast  = 1'b0;
        send(9, 18, 274, 273, mk(13, 5, 2), 0);
        send(10, 18, 274, 273, mk(13, 5, 3), 0);
        idle(4);
        expect_sym(8, 18, 118 - (18 - A), 1'b0, mk(13, 5, 1));
        expect_sym(10, 18, FFT, 1'b1, mk(13, 5, 3));
        checks++;
        bad = (out_q.size() != exp_q.size()) ? 1 : 0;
        for (int k = 0; k < exp_q.size() && k < out_q.size(); k++)
            if (out_q[k] !== exp_q[k]) begin
                if (bad == 0) $display("FAIL reset_mid sample %0d: got %h required %h", k, out_q[k], exp_q[k]);
                bad++;
            end
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid sequence: got %0d samples/%0d bad, required %0d samples", out_q.size(), bad, exp_q.size());
        end
        checks++;
        if ({n_short, n_long} !== {32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_mid errors: got short=%0d long=%0d required 0/0", n_short, n_long);
        end
    endtask

    initial begin
        test_reset();
        test_symbols(0);
        test_gaps();
        test_short();
        test_long();
        test_cp_edges();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
